// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, horizontal and vertical
// phase FSMs, and registered sync/active/coordinate/strobe outputs.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] H_FP_END   = CW'(H_ACTIVE + H_FP - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] V_FP_END   = CW'(V_ACTIVE + V_FP - 1);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_e;

    phase_e        hph_q, hph_d;
    phase_e        vph_q, vph_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          h_last;

    // Phase leaves its region on the tick that consumes the region's last count.
    function automatic phase_e next_phase(input phase_e cur, input logic [CW-1:0] cnt,
                                          input logic [CW-1:0] act_end,
                                          input logic [CW-1:0] fp_end,
                                          input logic [CW-1:0] sync_end,
                                          input logic [CW-1:0] last);
        phase_e nxt;
        nxt = cur;
        case (cur)
            PH_ACTIVE: if (cnt == act_end)  nxt = PH_FP;
            PH_FP:     if (cnt == fp_end)   nxt = PH_SYNC;
            PH_SYNC:   if (cnt == sync_end) nxt = PH_BP;
            PH_BP:     if (cnt == last)     nxt = PH_ACTIVE;
            default:                        nxt = PH_ACTIVE;
        endcase
        return nxt;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hph_q         <= PH_ACTIVE;
            vph_q         <= PH_ACTIVE;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hph_q         <= hph_d;
            vph_q         <= vph_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        hph_d         = hph_q;
        vph_d         = vph_q;
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_last        = (h_q == H_LAST);

        if (pix_en) begin
            h_d   = h_last ? '0 : h_q + 1'b1;
            hph_d = next_phase(hph_q, h_q, H_ACT_END, H_FP_END, H_SYNC_END, H_LAST);
            if (h_last) begin
                v_d   = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                vph_d = next_phase(vph_q, v_q, V_ACT_END, V_FP_END, V_SYNC_END, V_LAST);
            end

            // Outputs describe the pixel held in the counters before this tick.
            hsync_d       = (hph_q == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync_d       = (vph_q == PH_SYNC) ? VS_POL : ~VS_POL;
            active_d      = (hph_q == PH_ACTIVE) && (vph_q == PH_ACTIVE);
            x_d           = active_d ? h_q : '0;
            y_d           = active_d ? v_q : '0;
            line_start_d  = (h_q == '0);
            frame_start_d = (h_q == '0) && (v_q == '0);
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance for line-level behaviour and
// a tiny-raster instance (inverted polarities) for frame-level behaviour.
module tb_vga_sync_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a = 1'b0, pe_a = 1'b0;
    logic       hs_a, vs_a, act_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       reset_b = 1'b0, pe_b = 1'b0;
    logic       hs_b, vs_b, act_b, ls_b, fs_b;
    logic [3:0] x_b, y_b;

    vga_sync_gen dut_a (
        .clock(clk), .reset(reset_a), .pix_en(pe_a),
        .hsync(hs_a), .vsync(vs_a), .active(act_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
    ) dut_b (
        .clock(clk), .reset(reset_b), .pix_en(pe_b),
        .hsync(hs_b), .vsync(vs_b), .active(act_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          ka = 0, kb = 0;
    out_t        exa, exb;
    out_t        rst_a = '{hs: 1'b1, vs: 1'b1, act: 1'b0, x: '0, y: '0, ls: 1'b0, fs: 1'b0};
    out_t        rst_b = '{hs: 1'b0, vs: 1'b0, act: 1'b0, x: '0, y: '0, ls: 1'b0, fs: 1'b0};

    // Outputs for the k-th tick since reset, derived from raster arithmetic.
    function automatic out_t ref_pix(input int k, input int ha, input int hfp, input int hsw,
                                     input int hbp, input int va, input int vfp, input int vsw,
                                     input int vbp, input bit hp, input bit vp);
        int   ht, vt, h, v;
        out_t r;
        ht    = ha + hfp + hsw + hbp;
        vt    = va + vfp + vsw + vbp;
        h     = k % ht;
        v     = (k / ht) % vt;
        r.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? hp : ~hp;
        r.vs  = (v >= va + vfp && v < va + vfp + vsw) ? vp : ~vp;
        r.act = (h < ha) && (v < va);
        r.x   = r.act ? 10'(h) : 10'd0;
        r.y   = r.act ? 10'(v) : 10'd0;
        r.ls  = (h == 0);
        r.fs  = (h == 0) && (v == 0);
        return r;
    endfunction

    function automatic out_t ref_a(input int k);
        return ref_pix(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction

    function automatic out_t ref_b(input int k);
        return ref_pix(k, 8, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b1);
    endfunction

    function automatic out_t got_a();
        out_t r;
        r = {hs_a, vs_a, act_a, x_a, y_a, ls_a, fs_a};
        return r;
    endfunction

    function automatic out_t got_b();
        out_t r;
        r = {hs_b, vs_b, act_b, 6'd0, x_b, 6'd0, y_b, ls_b, fs_b};
        return r;
    endfunction

    // One clock with the given ticks; advances both reference models.
    task automatic cycle(input logic pa, input logic pb);
        pe_a = pa;
        pe_b = pb;
        @(posedge clk);
        #1;
        if (!reset_a) begin ka = 0; exa = rst_a; end
        else if (pa) begin exa = ref_a(ka); ka++; end
        else begin exa.ls = 1'b0; exa.fs = 1'b0; end
        if (!reset_b) begin kb = 0; exb = rst_b; end
        else if (pb) begin exb = ref_b(kb); kb++; end
        else begin exb.ls = 1'b0; exb.fs = 1'b0; end
    endtask

    task automatic test_reset();
        out_t g;
        reset_a = 1'b0;
        reset_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1);
            g = got_a();
            n_checks++;
            if (g !== rst_a) begin
                n_fail++;
                $display("FAIL reset_a @%0t: got %h expected %h", $time, g, rst_a);
            end
            g = got_b();
            n_checks++;
            if (g !== rst_b) begin
                n_fail++;
                $display("FAIL reset_b @%0t: got %h expected %h", $time, g, rst_b);
            end
        end
        pe_a    = 1'b0;
        pe_b    = 1'b0;
        reset_a = 1'b1;
        reset_b = 1'b1;
    endtask

    task automatic test_first_tick();
        out_t g;
        out_t c0 = '{hs: 1'b1, vs: 1'b1, act: 1'b1, x: '0, y: '0, ls: 1'b1, fs: 1'b1};
        cycle(1'b1, 1'b0);
        g = got_a();
        n_checks++;
        if (g !== c0) begin
            n_fail++;
            $display("FAIL first_tick: got %h expected %h", g, c0);
        end
        cycle(1'b1, 1'b0);
        g = got_a();
        n_checks++;
        if (g !== exa || g.fs !== 1'b0 || g.ls !== 1'b0 || g.x !== 10'd1) begin
            n_fail++;
            $display("FAIL second_tick: got %h expected %h", g, exa);
        end
    endtask

    task automatic test_line_div1();
        out_t g;
        int   idx, n_act = 0, n_hs = 0, fall_h = -1, last_ls = -1, period = -1;
        logic prev_hs = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            cycle(1'b1, 1'b0);
            g = got_a();
            n_checks++;
            if (g !== exa) begin
                n_fail++;
                $display("FAIL line_div1 @%0t: got %h expected %h", $time, g, exa);
            end
            idx = ka - 1;
            if (idx >= 800 && idx < 1600) begin
                if (g.act) n_act++;
                if (!g.hs) n_hs++;
                if (!g.hs && prev_hs) fall_h = idx % 800;
            end
            prev_hs = g.hs;
            if (g.ls) begin
                if (last_ls >= 0) period = i - last_ls;
                last_ls = i;
            end
        end
        n_checks++;
        if (n_act != 640) begin
            n_fail++;
            $display("FAIL active_count: got %0d expected 640", n_act);
        end
        n_checks++;
        if (n_hs != 96) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d expected 96", n_hs);
        end
        n_checks++;
        if (fall_h != 656) begin
            n_fail++;
            $display("FAIL hsync_start: got %0d expected 656", fall_h);
        end
        n_checks++;
        if (period != 800) begin
            n_fail++;
            $display("FAIL line_period_div1: got %0d expected 800", period);
        end
    endtask

    task automatic test_line_div2();
        out_t g;
        int   last_ls = -1, period = -1;
        logic prev_ls = 1'b0;
        for (int i = 0; i < 3200; i++) begin
            cycle((i % 2) == 0, 1'b0);
            g = got_a();
            n_checks++;
            if (g !== exa) begin
                n_fail++;
                $display("FAIL line_div2 @%0t: got %h expected %h", $time, g, exa);
            end
            if (g.ls) begin
                n_checks++;
                if (prev_ls) begin
                    n_fail++;
                    $display("FAIL strobe_width: got 2+ clocks expected 1");
                end
                if (last_ls >= 0) period = i - last_ls;
                last_ls = i;
            end
            prev_ls = g.ls;
        end
        n_checks++;
        if (period != 1600) begin
            n_fail++;
            $display("FAIL line_period_div2: got %0d expected 1600", period);
        end
    endtask

    task automatic test_random_a();
        out_t g;
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b0);
            g = got_a();
            n_checks++;
            if (g !== exa) begin
                n_fail++;
                $display("FAIL random_a @%0t: got %h expected %h", $time, g, exa);
            end
        end
    endtask

    task automatic test_reset_midline_a();
        out_t g;
        out_t c0 = '{hs: 1'b1, vs: 1'b1, act: 1'b1, x: '0, y: '0, ls: 1'b1, fs: 1'b1};
        reset_a = 1'b0;
        cycle(1'b0, 1'b0);
        reset_a = 1'b1;
        for (int i = 0; i < 700; i++) begin
            cycle(1'b1, 1'b0);
            g = got_a();
            n_checks++;
            if (g !== exa) begin
                n_fail++;
                $display("FAIL run_to_700 @%0t: got %h expected %h", $time, g, exa);
            end
        end
        #3;
        reset_a = 1'b0;
        #1;
        ka  = 0;
        exa = rst_a;
        g   = got_a();
        n_checks++;
        if (g !== rst_a) begin
            n_fail++;
            $display("FAIL async_reset_a: got %h expected %h", g, rst_a);
        end
        @(posedge clk);
        #1;
        reset_a = 1'b1;
        cycle(1'b1, 1'b0);
        g = got_a();
        n_checks++;
        if (g !== c0) begin
            n_fail++;
            $display("FAIL tick_after_reset_a: got %h expected %h", g, c0);
        end
    endtask

    task automatic test_frame_b();
        out_t g;
        int   n_vs = 0, y_max = 0, last_fs = -1, period = -1;
        for (int i = 0; i < 330; i++) begin
            cycle(1'b0, 1'b1);
            g = got_b();
            n_checks++;
            if (g !== exb) begin
                n_fail++;
                $display("FAIL frame_b @%0t: got %h expected %h", $time, g, exb);
            end
            if (kb - 1 < 165) begin
                if (g.vs) n_vs++;
                if (g.act && int'(g.y) > y_max) y_max = int'(g.y);
            end
            if (g.fs) begin
                if (last_fs >= 0) period = i - last_fs;
                last_fs = i;
            end
        end
        n_checks++;
        if (n_vs != 30) begin
            n_fail++;
            $display("FAIL vsync_width: got %0d expected 30", n_vs);
        end
        n_checks++;
        if (y_max != 5) begin
            n_fail++;
            $display("FAIL y_max: got %0d expected 5", y_max);
        end
        n_checks++;
        if (period != 165) begin
            n_fail++;
            $display("FAIL frame_period: got %0d expected 165", period);
        end
        for (int i = 0; i < 600; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)));
            g = got_b();
            n_checks++;
            if (g !== exb) begin
                n_fail++;
                $display("FAIL random_b @%0t: got %h expected %h", $time, g, exb);
            end
        end
    endtask

    task automatic test_reset_midframe_b();
        out_t g;
        out_t c0 = '{hs: 1'b0, vs: 1'b0, act: 1'b1, x: '0, y: '0, ls: 1'b1, fs: 1'b1};
        reset_b = 1'b0;
        cycle(1'b0, 1'b0);
        reset_b = 1'b1;
        for (int i = 0; i < 117; i++) begin
            cycle(1'b0, 1'b1);
            g = got_b();
            n_checks++;
            if (g !== exb) begin
                n_fail++;
                $display("FAIL run_midframe_b @%0t: got %h expected %h", $time, g, exb);
            end
        end
        #3;
        reset_b = 1'b0;
        #1;
        kb  = 0;
        exb = rst_b;
        g   = got_b();
        n_checks++;
        if (g !== rst_b) begin
            n_fail++;
            $display("FAIL async_reset_b: got %h expected %h", g, rst_b);
        end
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        cycle(1'b0, 1'b1);
        g = got_b();
        n_checks++;
        if (g !== c0) begin
            n_fail++;
            $display("FAIL tick_after_reset_b: got %h expected %h", g, c0);
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_line_div1();
        test_line_div2();
        test_random_a();
        test_reset_midline_a();
        test_frame_b();
        test_reset_midframe_b();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
